// File: rtl/booth4_pkg.sv
// booth4_pkg: shared states, Booth window codes and widths for the radix-4 sequencer
package booth4_pkg;
  localparam int OP_W    = 8;
  localparam int PP_W    = 10;
  localparam int PROD_W  = 16;
  localparam int NUM_WIN = 4;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam logic [2:0] W_ZERO0 = 3'b000;
  localparam logic [2:0] W_PA0   = 3'b001;
  localparam logic [2:0] W_PA1   = 3'b010;
  localparam logic [2:0] W_P2A   = 3'b011;
  localparam logic [2:0] W_M2A   = 3'b100;
  localparam logic [2:0] W_MA0   = 3'b101;
  localparam logic [2:0] W_MA1   = 3'b110;
  localparam logic [2:0] W_ZERO1 = 3'b111;
endpackage

// File: rtl/mul_comp.sv
// mul_comp: 9-bit Booth partial product of an 8-bit operand for one 3-bit window
module mul_comp import booth4_pkg::*; (
  input  logic [OP_W-1:0] data,
  input  logic [2:0]      win,
  output logic [OP_W:0]   res
);
  logic [OP_W:0] a1, a2;
  assign a1 = {data[OP_W-1], data};
  assign a2 = {data, 1'b0};
  // select 0, +-a or +-2a; -2*(-128) wraps to -256 in 9 bits
  always_comb res = (win == W_PA0 || win == W_PA1) ? a1 :
                    (win == W_P2A)                 ? a2 :
                    (win == W_M2A)                 ? -a2 :
                    (win == W_MA0 || win == W_MA1) ? -a1 : '0;
endmodule

// File: rtl/booth4_mul_seq.sv
// booth4_mul_seq: signed 8x8 radix-4 Booth multiplier, one window per cycle
module booth4_mul_seq import booth4_pkg::*; #(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [OP_W-1:0]   a_i,
  input  logic [OP_W-1:0]   b_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [PROD_W-1:0] product_o,
  output logic              busy_o
);
  state_t state, state_nxt;
  logic [OP_W-1:0]   mcand;
  logic [OP_W:0]     mplr, pp9;
  logic [PP_W-1:0]   pp10;
  logic [PROD_W-1:0] acc, acc_nxt, pp16;
  logic [1:0]        cnt;
  logic              last;
  mul_comp u_pp (.data(mcand), .win(mplr[2:0]), .res(pp9));
  // -2*(-128) = +256 does not fit the unit's 9-bit result, so patch it here
  assign pp10 = (mcand == 8'h80 && mplr[2:0] == W_M2A) ? 10'd256 : {pp9[OP_W], pp9};
  assign pp16 = {{(PROD_W-PP_W){pp10[PP_W-1]}}, pp10};
  assign acc_nxt = acc + (pp16 << {cnt, 1'b0});
  // mplr[8:2] holds b[7:2i+1] sign-extended; uniform bits mean only zero windows remain
  assign last = cnt == 2'(NUM_WIN-1) || (EARLY_EXIT && (mplr[OP_W:2] == '0 || mplr[OP_W:2] == '1));
  assign in_ready_o  = state == IDLE;
  assign out_valid_o = state == DONE;
  assign busy_o      = state == CALC || state == DONE;
  // state register
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= IDLE;
    else state <= state_nxt;
  // next-state: capture, iterate windows, hold result until consumed
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid_i) state_nxt = CALC;
      CALC: if (last) state_nxt = DONE;
      DONE: if (out_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // datapath: load operands, shift-add one window per CALC cycle, latch product on exit
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      mcand     <= '0;
      mplr      <= '0;
      acc       <= '0;
      cnt       <= '0;
      product_o <= '0;
    end else if (state == IDLE && in_valid_i) begin
      mcand <= a_i;
      mplr  <= {b_i, 1'b0};
      acc   <= '0;
      cnt   <= '0;
    end else if (state == CALC) begin
      acc  <= acc_nxt;
      mplr <= {mplr[OP_W], mplr[OP_W], mplr[OP_W:2]};
      cnt  <= cnt + 2'd1;
      if (last) product_o <= acc_nxt;
    end
endmodule

// File: tb/tb_booth4_mul_seq.sv
// tb_booth4_mul_seq: vector table plus corner sequences on early-exit and full-length instances
module tb_booth4_mul_seq;
  logic clk = 1'b0, rst_ni = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic rdy1, ov1, busy1, rdy4, ov4, busy4;
  logic [15:0] p1, p4;
  int checks = 0, failures = 0;
  logic [15:0] q1[$], q4[$];
  typedef struct {logic [7:0] a; logic [7:0] b; logic [15:0] p; int n;} vec_t;
  vec_t vecs[9];

  always #5 clk = ~clk;

  booth4_mul_seq #(.EARLY_EXIT(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .in_valid_i(in_valid), .in_ready_o(rdy1),
    .a_i(a), .b_i(b), .out_valid_o(ov1), .out_ready_i(out_ready),
    .product_o(p1), .busy_o(busy1));
  booth4_mul_seq #(.EARLY_EXIT(1'b0)) dut4 (
    .clk_i(clk), .rst_ni(rst_ni), .in_valid_i(in_valid), .in_ready_o(rdy4),
    .a_i(a), .b_i(b), .out_valid_o(ov4), .out_ready_i(out_ready),
    .product_o(p4), .busy_o(busy4));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (rst_ni && ov1 && out_ready) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_ee1_unexpected: product %h with nothing pending", p1);
      end else chk("sb_ee1_product", p1, q1.pop_front());
    end

  always @(negedge clk)
    if (rst_ni && ov4 && out_ready) begin
      if (q4.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_ee0_unexpected: product %h with nothing pending", p4);
      end else chk("sb_ee0_product", p4, q4.pop_front());
    end

  task automatic issue(input logic [7:0] va, input logic [7:0] vb, input logic [15:0] ep);
    int t = 0;
    @(negedge clk);
    while (!(rdy1 && rdy4) && t < 20) begin @(negedge clk); t++; end
    chk("issue_ready", {rdy1, rdy4}, 2'b11);
    q1.push_back(ep);
    q4.push_back(ep);
    in_valid = 1'b1; a = va; b = vb;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(input int en1, input string tag);
    int n1 = 0, n4 = 0, t = 0;
    while (!(ov1 && ov4) && t < 20) begin
      @(negedge clk);
      if (busy1 && !ov1) n1++;
      if (busy4 && !ov4) n4++;
      t++;
    end
    chk({tag, "_calc_ee1"}, n1, en1);
    chk({tag, "_calc_ee0"}, n4, 4);
  endtask

  task automatic release_out();
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("idle_after_release", {rdy1, ov1, rdy4, ov4}, 4'b1010);
  endtask

  initial begin
    int nv;
    vecs[0] = '{8'h03, 8'h05, 16'h000F, 2};
    vecs[1] = '{8'h80, 8'h80, 16'h4000, 4};
    vecs[2] = '{8'h7F, 8'h80, 16'hC080, 4};
    vecs[3] = '{8'hFF, 8'hFF, 16'h0001, 1};
    vecs[4] = '{8'h7F, 8'h00, 16'h0000, 1};
    vecs[5] = '{8'hFB, 8'h07, 16'hFFDD, 2};
    vecs[6] = '{8'h19, 8'hFD, 16'hFFB5, 2};
    vecs[7] = '{8'h80, 8'h7F, 16'hC080, 4};
    vecs[8] = '{8'h80, 8'hFF, 16'h0080, 1};
    repeat (2) @(negedge clk);
    chk("reset_outputs", {rdy1, ov1, busy1, rdy4, ov4, busy4}, 6'b100100);
    chk("reset_product", {p1, p4}, 32'h0);
    rst_ni = 1'b1;
    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].p);
      wait_done(vecs[i].n, $sformatf("vec%0d", i));
      release_out();
    end
    // backpressure: hold the result while a new operand pair is offered
    issue(8'h03, 8'h05, 16'h000F);
    wait_done(2, "bp");
    in_valid = 1'b1; a = 8'h01; b = 8'h01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold", {p1, p4, rdy1, rdy4, ov1, ov4}, {16'h000F, 16'h000F, 4'b0011});
    end
    in_valid = 1'b0;
    release_out();
    chk("bp_not_captured", q1.size() + q4.size(), 0);
    repeat (2) @(negedge clk);
    chk("bp_stay_idle", {busy1, ov1, busy4, ov4}, 4'b0000);
    // asynchronous reset in the second CALC cycle
    issue(8'h80, 8'h80, 16'h4000);
    @(posedge clk);
    #2 rst_ni = 1'b0;
    #1 chk("midreset_outputs", {rdy1, ov1, busy1, rdy4, ov4, busy4}, 6'b100100);
    chk("midreset_product", {p1, p4}, 32'h0);
    q1.delete();
    q4.delete();
    #1 rst_ni = 1'b1;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ov1 || ov4 || busy1 || busy4) nv++;
    end
    chk("midreset_no_output", nv, 0);
    issue(8'hFB, 8'h07, 16'hFFDD);
    wait_done(2, "post_reset");
    release_out();
    chk("queues_drained", q1.size() + q4.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/booth4_mul_seq.md
# booth4_mul_seq

Multi-cycle sequencer for a signed 8x8 radix-4 Booth multiplication.
- Takes one operand pair per valid/ready handshake.
- Each cycle, feeds one 3-bit Booth window of the multiplier to a single shared partial-product unit.
- Accumulates the shifted partial products into a 16-bit product.
- Presents the product on a valid/ready output port.
- Sits between an upstream operand source and a downstream consumer.
- Trades area (one partial-product unit, one adder) for 1-4 compute cycles per operation.

## Interface
- EARLY_EXIT, 1: when 1, finish as soon as all remaining Booth windows decode to zero; when 0, always run 4 compute cycles.
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- in_valid_i  in  1  operand pair valid.
- in_ready_o  out  1  block can accept operands; equals (state == IDLE).
- a_i  in  8  multiplicand, two's complement.
- b_i  in  8  multiplier, two's complement.
- out_valid_o  out  1  product_o valid.
- out_ready_i  in  1  consumer accepts product.
- product_o  out  16  signed product a_i*b_i; registered.
- busy_o  out  1  high in CALC and DONE.

## Operation
- Operand capture:
  - Registers mcand (8b).
  - Registers mplr, a 9b shift register loaded with {b_i, 1'b0}.
  - Registers acc (16b), cleared to 0.
  - Registers cnt (2b), cleared to 0.
- FSM IDLE:
  - in_ready_o=1.
  - If in_valid_i: capture the operands and go to CALC. Otherwise stay in IDLE.
- FSM CALC:
  - window = mplr[2:0], which equals {b[2i+1], b[2i], b[2i-1]} with b[-1]=0, where i = cnt.
  - window drives the partial-product unit together with mcand.
  - pp10 = sign-extend of the unit's 9b result.
  - Exception: if mcand==8'h80 and window==3'b100, force pp10 = +256. The 9b unit wraps this case to -256.
  - acc <= acc + (sext16(pp10) << 2*cnt), modulo 2^16.
  - mplr <= mplr >>> 2 (arithmetic shift).
  - cnt <= cnt+1.
- CALC exit: go to DONE after processing window i if either condition holds.
  - i==3.
  - EARLY_EXIT==1 and b[7:2i+1] are all 0 or all 1. All later windows are then 000 or 111, which contribute zero.
- FSM DONE:
  - out_valid_o=1; product_o = acc, held stable.
  - If out_ready_i: go to IDLE.
  - in_ready_o=0, so in_valid_i is ignored.
- Window decode is the team-standard Booth code:
  - 000 and 111 select 0.
  - 001 and 010 select +a.
  - 011 selects +2a.
  - 100 selects -2a.
  - 101 and 110 select -a.
- No other illegal states. Any unencoded state returns to IDLE.

## Timing
- Reset values: state=IDLE, in_ready_o=1, out_valid_o=0, product_o=0, busy_o=0, acc=0, cnt=0.
- Reset is effective mid-operation. It aborts any CALC/DONE and discards the operation.
- Input handshake completes in cycle 0 (in_valid_i and in_ready_o both high at the edge).
- CALC occupies cycles 1..N:
  - N=4 when EARLY_EXIT=0.
  - N is 1-4 when EARLY_EXIT=1.
- out_valid_o rises in cycle N+1 and stays high until the edge where out_ready_i=1.
- in_ready_o rises the cycle after the output handshake. Minimum issue interval is N+2 cycles.
- product_o is unchanged from DONE entry until the next operation's DONE entry; it is not cleared in IDLE.
- out_ready_i asserted before DONE has no effect.
- Throughput: one operation in flight; no overlap of input and output handshakes.

## Structure
- booth4_pkg holds:
  - The state enum (IDLE, CALC, DONE).
  - The Booth window localparams (values listed under Operation).
  - OP_W=8, PP_W=10, PROD_W=16, NUM_WIN=4.
- One sub-module: a single instance of the existing mul_comp partial-product unit (8b data, 3b window, 9b result).
- The sequencer owns the sign extension, the -2*(-128) correction, the shift-add and the FSM.

## Test plan
- Reset, then a=3, b=5, EARLY_EXIT=1:
  - 2 CALC cycles.
  - out_valid_o in cycle 3.
  - product_o=16'h000F.
- a=8'h80, b=8'h80:
  - 4 CALC cycles.
  - Window 3 hits the correction path.
  - product_o=16'h4000 (+16384).
- a=8'h7F, b=8'h80 → product_o=16'hC080 (-16256).
- Early exit at i=0, each with 1 CALC cycle:
  - a=8'hFF, b=8'hFF → product_o=16'h0001.
  - a=8'h7F, b=0 → product_o=16'h0000.
  - With EARLY_EXIT=0, the same vectors take 4 CALC cycles and give the same results.
- Backpressure:
  - Hold out_ready_i=0 for 3 cycles in DONE.
  - product_o must be stable and in_ready_o=0.
  - A concurrent in_valid_i with a=1, b=1 is not captured.
  - Release out_ready_i: IDLE is reached one cycle later.
- Reset mid-CALC:
  - Pulse rst_ni low during cycle 2 of a=8'h80, b=8'h80.
  - All outputs take their reset values immediately.
  - No out_valid_o occurs afterwards without a new input handshake.
